// File: rtl/aidc_lite_pkg.sv
// Shared constants for the AIDC-lite compressors: algorithm IDs, line geometry,
// ZRLE prefix codes and code lengths, FSM state type.
package aidc_lite_pkg;

    localparam logic [1:0] ALGO_RAW  = 2'b00;
    localparam logic [1:0] ALGO_ZRLE = 2'b01;
    localparam logic [1:0] ALGO_BDI  = 2'b10;
    localparam logic [1:0] ALGO_FPC  = 2'b11;

    localparam int CHUNKS_PER_LINE = 8;
    localparam int ZRLE_MAX_WORDS  = 17;
    localparam int BUF_W           = 128;

    localparam logic [6:0] ENC_READY_MAX = 7'd62;
    localparam logic [6:0] WORD_BITS     = 7'd32;

    // Code lengths: prefix plus the non-zero words it carries.
    localparam logic [6:0] LEN_ZZZZ = 7'd6;
    localparam logic [6:0] LEN_ZZZN = 7'd22;
    localparam logic [6:0] LEN_N1   = 7'd21;
    localparam logic [6:0] LEN_N2   = 7'd36;
    localparam logic [6:0] LEN_N3   = 7'd52;
    localparam logic [6:0] LEN_N4   = 7'd66;

    // Prefix values, right-aligned; pattern letters are w3..w0.
    localparam logic [5:0] PFX_ZZZZ = 6'b000000;
    localparam logic [5:0] PFX_ZZZN = 6'b000001;
    localparam logic [5:0] PFX_ZZNZ = 6'b000001;
    localparam logic [5:0] PFX_ZNZZ = 6'b000010;
    localparam logic [5:0] PFX_NZZZ = 6'b000011;
    localparam logic [5:0] PFX_ZZNN = 6'b000010;
    localparam logic [5:0] PFX_ZNZN = 6'b000011;
    localparam logic [5:0] PFX_NZZN = 6'b000100;
    localparam logic [5:0] PFX_ZNNZ = 6'b000101;
    localparam logic [5:0] PFX_NZNZ = 6'b000110;
    localparam logic [5:0] PFX_NNZZ = 6'b000111;
    localparam logic [5:0] PFX_ZNNN = 6'b001000;
    localparam logic [5:0] PFX_NZNN = 6'b001001;
    localparam logic [5:0] PFX_NNZN = 6'b001010;
    localparam logic [5:0] PFX_NNNZ = 6'b001011;
    localparam logic [5:0] PFX_NNNN = 6'b000011;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ENC   = 2'd1,
        ST_FLUSH = 2'd2
    } zrle_state_e;

    function automatic logic [5:0] pfx_align(input logic [5:0] v, input logic [2:0] plen);
        return v << (3'd6 - plen);
    endfunction

endpackage

// File: rtl/aidc_lite_zrle_chunk_enc.sv
// Combinational ZRLE encoder for one 64-bit chunk: left-aligned prefix plus
// non-zero words (w3 first); no latency, no flow control.
module aidc_lite_zrle_chunk_enc
    import aidc_lite_pkg::*;
(
    input  logic [63:0] data,
    output logic [65:0] code,
    output logic [6:0]  len
);

    logic [3:0]  nz;
    logic [5:0]  pfx;
    logic [2:0]  plen;
    logic [63:0] words;
    logic [6:0]  pos;

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            nz[i] = |data[16*i +: 16];
        end

        pfx  = PFX_ZZZZ;
        plen = 3'd6;
        len  = LEN_ZZZZ;
        case (nz)
            4'b0000: begin pfx = PFX_ZZZZ; plen = 3'd6; len = LEN_ZZZZ; end
            4'b0001: begin pfx = PFX_ZZZN; plen = 3'd6; len = LEN_ZZZN; end
            4'b0010: begin pfx = PFX_ZZNZ; plen = 3'd5; len = LEN_N1;   end
            4'b0100: begin pfx = PFX_ZNZZ; plen = 3'd5; len = LEN_N1;   end
            4'b1000: begin pfx = PFX_NZZZ; plen = 3'd5; len = LEN_N1;   end
            4'b0011: begin pfx = PFX_ZZNN; plen = 3'd4; len = LEN_N2;   end
            4'b0101: begin pfx = PFX_ZNZN; plen = 3'd4; len = LEN_N2;   end
            4'b1001: begin pfx = PFX_NZZN; plen = 3'd4; len = LEN_N2;   end
            4'b0110: begin pfx = PFX_ZNNZ; plen = 3'd4; len = LEN_N2;   end
            4'b1010: begin pfx = PFX_NZNZ; plen = 3'd4; len = LEN_N2;   end
            4'b1100: begin pfx = PFX_NNZZ; plen = 3'd4; len = LEN_N2;   end
            4'b0111: begin pfx = PFX_ZNNN; plen = 3'd4; len = LEN_N3;   end
            4'b1011: begin pfx = PFX_NZNN; plen = 3'd4; len = LEN_N3;   end
            4'b1101: begin pfx = PFX_NNZN; plen = 3'd4; len = LEN_N3;   end
            4'b1110: begin pfx = PFX_NNNZ; plen = 3'd4; len = LEN_N3;   end
            4'b1111: begin pfx = PFX_NNNN; plen = 3'd2; len = LEN_N4;   end
            default: begin pfx = PFX_ZZZZ; plen = 3'd6; len = LEN_ZZZZ; end
        endcase

        // Gather non-zero words into a left-aligned field, w3 first.
        words = '0;
        pos   = '0;
        for (int i = 3; i >= 0; i--) begin
            if (nz[i]) begin
                words = words | ({data[16*i +: 16], 48'b0} >> pos);
                pos   = pos + 7'd16;
            end
        end

        code = {pfx_align(pfx, plen), 60'b0} | ({words, 2'b00} >> plen);
    end

endmodule

// File: rtl/aidc_lite_comp_zrle.sv
// ZRLE line compressor: 8x64-bit chunks in, sop/eop-framed 32-bit words out; first word 2 cycles
// after the chunk that fills 32 bits. ready_o throttles input to bound the buffer; no output backpressure.
module aidc_lite_comp_zrle
    import aidc_lite_pkg::*;
#(
    parameter logic [1:0] ALGO_ID = ALGO_ZRLE
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        valid_i,
    output logic        ready_o,
    input  logic [63:0] data_i,
    output logic        valid_o,
    output logic        sop_o,
    output logic        eop_o,
    output logic [31:0] data_o,
    output logic [4:0]  size_o
);

    zrle_state_e      state_q, state_d;
    logic [BUF_W-1:0] buf_q, buf_d, buf_s;
    logic [6:0]       size_q, size_d, size_s;
    logic [2:0]       cnt_q;
    logic [4:0]       wcnt_q;
    logic             sop_pend_q;

    logic             emit;
    logic             emit_last;
    logic             accept;
    logic [65:0]      code;
    logic [6:0]       len;

    aidc_lite_zrle_chunk_enc u_chunk_enc (
        .data (data_i),
        .code (code),
        .len  (len)
    );

    assign accept = valid_i & ready_o;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (accept) state_d = ST_ENC;
            ST_ENC:   if (accept && cnt_q == 3'(CHUNKS_PER_LINE - 1)) state_d = ST_FLUSH;
            ST_FLUSH: if (emit_last) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Capping ENC acceptance at 62 buffered bits keeps the buffer within 98 bits.
    always_comb begin
        ready_o   = 1'b0;
        emit      = 1'b0;
        emit_last = 1'b0;
        case (state_q)
            ST_IDLE: ready_o = 1'b1;
            ST_ENC: begin
                ready_o = (size_q <= ENC_READY_MAX);
                emit    = (size_q >= WORD_BITS);
            end
            ST_FLUSH: begin
                emit      = (size_q > WORD_BITS);
                emit_last = (size_q <= WORD_BITS);
            end
            default: ready_o = 1'b0;
        endcase
    end

    always_comb begin
        buf_s  = emit ? {buf_q[BUF_W-33:0], 32'b0} : buf_q;
        size_s = emit ? (size_q - WORD_BITS) : size_q;
        buf_d  = buf_s;
        size_d = size_s;
        if (emit_last) begin
            buf_d  = '0;
            size_d = '0;
        end else if (accept) begin
            if (state_q == ST_IDLE) begin
                buf_d  = {ALGO_ID, code, 60'b0};
                size_d = 7'd2 + len;
            end else begin
                buf_d  = buf_s | ({code, 62'b0} >> size_s);
                size_d = size_s + len;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            buf_q      <= '0;
            size_q     <= '0;
            cnt_q      <= '0;
            wcnt_q     <= '0;
            sop_pend_q <= 1'b0;
            valid_o    <= 1'b0;
            sop_o      <= 1'b0;
            eop_o      <= 1'b0;
            data_o     <= '0;
            size_o     <= '0;
        end else begin
            buf_q  <= buf_d;
            size_q <= size_d;
            if (accept) begin
                cnt_q <= (state_q == ST_IDLE) ? 3'd1 : cnt_q + 3'd1;
            end
            if (accept && state_q == ST_IDLE) begin
                sop_pend_q <= 1'b1;
            end else if (emit) begin
                sop_pend_q <= 1'b0;
            end
            if (emit) begin
                wcnt_q <= sop_pend_q ? 5'd1 : wcnt_q + 5'd1;
            end
            valid_o <= emit | emit_last;
            sop_o   <= emit & sop_pend_q;
            eop_o   <= emit_last;
            data_o  <= (emit | emit_last) ? buf_q[BUF_W-1 -: 32] : 32'b0;
            size_o  <= emit_last ? (wcnt_q + 5'd1) : 5'd0;
        end
    end

endmodule

// File: tb/tb_aidc_lite_comp_zrle.sv
// Bench for aidc_lite_comp_zrle: directed and random lines checked against a
// bit-queue encoder and a prefix-table decoder.
module tb_aidc_lite_comp_zrle;

    localparam logic [1:0] ALGO = 2'b01;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid_i;
    logic        ready_o;
    logic [63:0] data_i;
    logic        valid_o;
    logic        sop_o;
    logic        eop_o;
    logic [31:0] data_o;
    logic [4:0]  size_o;

    int n_assert = 0;
    int n_fail   = 0;
    int stalls   = 0;

    logic [63:0] line_d [2][8];
    logic [31:0] exp_q [$];
    logic [31:0] got_w [$];
    bit          got_sop [$];
    bit          got_eop [$];
    logic [4:0]  got_sz [$];
    string       pfx_tbl [string];
    string       pfx_rev [string];

    int cyc = 0;
    int eop_cyc = 0;
    int gap = -1;
    bit seen_eop = 1'b0;

    aidc_lite_comp_zrle #(.ALGO_ID(ALGO)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .valid_i (valid_i),
        .ready_o (ready_o),
        .data_i  (data_i),
        .valid_o (valid_o),
        .sop_o   (sop_o),
        .eop_o   (eop_o),
        .data_o  (data_o),
        .size_o  (size_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        cyc++;
        if (valid_o) begin
            got_w.push_back(data_o);
            got_sop.push_back(sop_o);
            got_eop.push_back(eop_o);
            got_sz.push_back(size_o);
            chk("sop_eop_excl", {63'b0, sop_o & eop_o}, 64'd0);
            if (eop_o) chk("ready_at_eop", {63'b0, ready_o}, 64'd1);
            if (sop_o && seen_eop && gap < 0) gap = cyc - eop_cyc - 1;
            if (eop_o) begin
                eop_cyc  = cyc;
                seen_eop = 1'b1;
            end
        end else begin
            chk("idle_zero", {25'b0, data_o, size_o, sop_o, eop_o}, 64'd0);
        end
    end

    // Golden encoder: spec rules applied to a plain bit queue.
    task automatic model(input int L, output int n);
        bit b[$];
        string pat, p;
        logic [1:0] a;
        logic [15:0] w16;
        logic [31:0] w32;
        a = ALGO;
        b.push_back(a[1]);
        b.push_back(a[0]);
        for (int c = 0; c < 8; c++) begin
            pat = "";
            for (int w = 3; w >= 0; w--) begin
                w16 = line_d[L][c][16*w +: 16];
                if (w16 != 16'h0) pat = {pat, "N"}; else pat = {pat, "Z"};
            end
            p = pfx_tbl[pat];
            for (int k = 0; k < p.len(); k++) b.push_back(p[k] == "1");
            for (int w = 3; w >= 0; w--) begin
                w16 = line_d[L][c][16*w +: 16];
                if (w16 != 16'h0) for (int k = 15; k >= 0; k--) b.push_back(w16[k]);
            end
        end
        while (b.size() % 32 != 0) b.push_back(1'b0);
        n = b.size() / 32;
        for (int i = 0; i < n; i++) begin
            w32 = '0;
            for (int k = 0; k < 32; k++) w32[31-k] = b[32*i+k];
            exp_q.push_back(w32);
        end
    endtask

    // Decompressor model: walks the received words with the prefix table.
    task automatic decode(input int L, input int base, input int n, output int bad);
        bit b[$];
        string acc, pat;
        logic [63:0] ch;
        logic [31:0] w32;
        int pos;
        bad = 0;
        for (int i = 0; i < n; i++) begin
            w32 = got_w[base+i];
            for (int k = 31; k >= 0; k--) b.push_back(w32[k]);
        end
        if (b.size() < 2 || {b[0], b[1]} != ALGO) bad++;
        pos = 2;
        for (int c = 0; c < 8; c++) begin
            acc = "";
            while (!pfx_rev.exists(acc) && acc.len() < 6 && pos < b.size()) begin
                if (b[pos]) acc = {acc, "1"}; else acc = {acc, "0"};
                pos++;
            end
            if (!pfx_rev.exists(acc)) begin
                bad++;
                break;
            end
            pat = pfx_rev[acc];
            ch = '0;
            for (int w = 3; w >= 0; w--) begin
                if (pat[3-w] == "N") begin
                    for (int k = 15; k >= 0; k--) begin
                        if (pos < b.size()) ch[16*w+k] = b[pos];
                        pos++;
                    end
                end
            end
            if (ch !== line_d[L][c]) bad++;
        end
        for (int q = pos; q < b.size(); q++) if (b[q]) bad++;
        if ((pos + 31) / 32 != n) bad++;
    endtask

    task automatic send_chunk(input logic [63:0] d, input int gaps);
        int t;
        for (int g = 0; g < gaps; g++) begin
            @(negedge clk);
            valid_i = 1'b0;
            data_i  = {$urandom, $urandom};
        end
        @(negedge clk);
        valid_i = 1'b1;
        data_i  = d;
        t = 0;
        while (!ready_o && t < 500) begin
            stalls++;
            @(negedge clk);
            t++;
        end
        chk("ready_wait_bound", {63'b0, t < 500}, 64'd1);
    endtask

    task automatic drop_valid();
        @(negedge clk);
        valid_i = 1'b0;
        data_i  = '0;
    endtask

    task automatic run_line(input int L, input int maxgap, output int n);
        model(L, n);
        for (int c = 0; c < 8; c++) begin
            send_chunk(line_d[L][c], (maxgap == 0) ? 0 : int'($urandom_range(0, maxgap)));
        end
    endtask

    task automatic wait_words(input int n);
        int t;
        t = 0;
        while (got_w.size() < n && t < 2000) begin
            @(negedge clk);
            t++;
        end
        chk("output_wait_bound", {63'b0, got_w.size() >= n}, 64'd1);
    endtask

    task automatic check_line(input int L, input int base, input int n);
        int bad;
        for (int i = 0; i < n; i++) begin
            chk("data", 64'(got_w[base+i]), 64'(exp_q[base+i]));
            chk("sop", 64'(got_sop[base+i]), 64'(i == 0));
            chk("eop", 64'(got_eop[base+i]), 64'(i == n - 1));
            chk("size", 64'(got_sz[base+i]), (i == n - 1) ? 64'(n) : 64'd0);
        end
        decode(L, base, n, bad);
        chk("decode", 64'(bad), 64'd0);
    endtask

    task automatic clear_q();
        got_w.delete();
        got_sop.delete();
        got_eop.delete();
        got_sz.delete();
        exp_q.delete();
    endtask

    task automatic fill(input int L, input int pz);
        for (int c = 0; c < 8; c++) begin
            for (int w = 0; w < 4; w++) begin
                line_d[L][c][16*w +: 16] = ($urandom_range(0, 99) < pz) ? 16'h0
                                         : 16'($urandom_range(1, 65535));
            end
        end
    endtask

    task automatic check_reset_vals();
        chk("rst_valid", 64'(valid_o), 64'd0);
        chk("rst_sop",   64'(sop_o),   64'd0);
        chk("rst_eop",   64'(eop_o),   64'd0);
        chk("rst_data",  64'(data_o),  64'd0);
        chk("rst_size",  64'(size_o),  64'd0);
        chk("rst_ready", 64'(ready_o), 64'd1);
    endtask

    initial begin
        int n, n2, neop;
        pfx_tbl["ZZZZ"] = "000000"; pfx_tbl["ZZZN"] = "000001";
        pfx_tbl["ZZNZ"] = "00001";  pfx_tbl["ZNZZ"] = "00010";  pfx_tbl["NZZZ"] = "00011";
        pfx_tbl["ZZNN"] = "0010";   pfx_tbl["ZNZN"] = "0011";   pfx_tbl["NZZN"] = "0100";
        pfx_tbl["ZNNZ"] = "0101";   pfx_tbl["NZNZ"] = "0110";   pfx_tbl["NNZZ"] = "0111";
        pfx_tbl["ZNNN"] = "1000";   pfx_tbl["NZNN"] = "1001";   pfx_tbl["NNZN"] = "1010";
        pfx_tbl["NNNZ"] = "1011";   pfx_tbl["NNNN"] = "11";
        foreach (pfx_tbl[k]) pfx_rev[pfx_tbl[k]] = k;

        rst_n   = 1'b0;
        valid_i = 1'b0;
        data_i  = '0;
        repeat (3) @(negedge clk);
        check_reset_vals();
        rst_n = 1'b1;

        // All-zero line
        clear_q();
        for (int c = 0; c < 8; c++) line_d[0][c] = 64'h0;
        run_line(0, 0, n);
        drop_valid();
        wait_words(2);
        chk("zero_n", 64'(n), 64'd2);
        chk("zero_w0", 64'(got_w[0]), 64'h4000_0000);
        chk("zero_w1", 64'(got_w[1]), 64'h0);
        check_line(0, 0, n);

        // Single ZZZN chunk 0
        clear_q();
        line_d[0][0] = 64'h0000_0000_0000_1234;
        run_line(0, 0, n);
        drop_valid();
        wait_words(3);
        chk("zzzn_n", 64'(n), 64'd3);
        chk("zzzn_w0", 64'(got_w[0]), 64'h4112_3400);
        chk("zzzn_size", 64'(got_sz[2]), 64'd3);
        check_line(0, 0, n);

        // Incompressible line with valid held high
        clear_q();
        stalls = 0;
        for (int c = 0; c < 8; c++) line_d[0][c] = 64'hFFFF_FFFF_FFFF_FFFF;
        run_line(0, 0, n);
        drop_valid();
        wait_words(17);
        chk("ffff_n", 64'(n), 64'd17);
        chk("ffff_w0", 64'(got_w[0]), 64'h7FFF_FFFF);
        chk("ffff_last", 64'(got_w[16]), 64'hFFFF_C000);
        chk("ffff_size", 64'(got_sz[16]), 64'd17);
        chk("ffff_stalled", 64'(stalls > 0), 64'd1);
        check_line(0, 0, n);

        // Two random lines back to back
        clear_q();
        repeat (4) @(negedge clk);
        seen_eop = 1'b0;
        gap = -1;
        fill(0, 30);
        fill(1, 30);
        line_d[0][0] = {$urandom | 32'h0001_0001, $urandom | 32'h0001_0001};
        line_d[1][0] = {$urandom | 32'h0001_0001, $urandom | 32'h0001_0001};
        run_line(0, 0, n);
        run_line(1, 0, n2);
        drop_valid();
        wait_words(n + n2);
        check_line(0, 0, n);
        check_line(1, n, n2);
        chk("b2b_gap", 64'(gap >= 0 && gap <= 2), 64'd1);

        // Random zero mixes with random valid gaps
        for (int r = 0; r < 6; r++) begin
            clear_q();
            fill(0, (r % 3 == 0) ? 85 : ((r % 3 == 1) ? 50 : 15));
            run_line(0, 3, n);
            drop_valid();
            wait_words(n);
            check_line(0, 0, n);
        end

        // Reset after chunk 4 aborts the line
        clear_q();
        fill(0, 20);
        for (int c = 0; c < 5; c++) send_chunk(line_d[0][c], 0);
        @(negedge clk);
        valid_i = 1'b0;
        rst_n   = 1'b0;
        @(negedge clk);
        check_reset_vals();
        neop = 0;
        foreach (got_eop[i]) if (got_eop[i]) neop++;
        chk("abort_no_eop", 64'(neop), 64'd0);
        rst_n = 1'b1;
        clear_q();
        for (int c = 0; c < 8; c++) line_d[0][c] = 64'h0;
        run_line(0, 0, n);
        drop_valid();
        wait_words(2);
        repeat (4) @(negedge clk);
        chk("post_rst_count", 64'(got_w.size()), 64'd2);
        chk("post_rst_w0", 64'(got_w[0]), 64'h4000_0000);
        check_line(0, 0, n);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
